// File: rtl/axis_sort_param.sv
// AXI-Stream packet sorter: insertion-sorts one packet while loading, then streams it out.
// Generic width/depth, signed or unsigned compare, per-packet ascending/descending order.
module axis_sort_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_LEN    = 16,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  descending,
  input  logic                  tvalid,
  output logic                  tready,
  input  logic                  tlast,
  input  logic [DATA_WIDTH-1:0] tdata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic                  olast,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  busy,
  output logic                  trunc
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {LOAD_IDLE, LOAD, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_LEN];
  logic [DATA_WIDTH-1:0] mem_d [MAX_LEN];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  mode_q, mode_d;
  logic                  tready_q, tready_d;
  logic                  trunc_q, trunc_d;
  logic [MAX_LEN-1:0]    keep;
  logic                  in_hs, out_hs, mode_eff;

  // True when existing entry e stays ahead of new word x (ties keep arrival order).
  function automatic logic in_order(input logic [DATA_WIDTH-1:0] e,
                                    input logic [DATA_WIDTH-1:0] x,
                                    input logic                  desc);
    if (SIGNED_CMP) begin
      return desc ? ($signed(e) >= $signed(x)) : ($signed(e) <= $signed(x));
    end
    return desc ? (e >= x) : (e <= x);
  endfunction

  assign in_hs    = tvalid && tready_q;
  assign out_hs   = ovalid && oready;
  assign mode_eff = (state_q == LOAD_IDLE) ? descending : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      mode_q   <= 1'b0;
      tready_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      mode_q   <= mode_d;
      tready_q <= tready_d;
      trunc_q  <= trunc_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Parallel insertion: entries ahead of the new word stay, the rest shift up one slot.
  always_comb begin
    keep  = '0;
    mem_d = mem_q;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      keep[i] = (CW'(i) < count_q) && in_order(mem_q[i], tdata, mode_eff);
    end
    if (in_hs) begin
      mem_d[0] = keep[0] ? mem_q[0] : tdata;
      for (int i = 1; i < int'(MAX_LEN); i++) begin
        mem_d[i] = keep[i] ? mem_q[i] : (keep[i-1] ? tdata : mem_q[i-1]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    mode_d   = mode_q;
    trunc_d  = 1'b0;
    case (state_q)
      LOAD_IDLE: begin
        if (in_hs) begin
          mode_d  = descending;
          count_d = CW'(1);
          state_d = tlast ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (in_hs) begin
          count_d = count_q + CW'(1);
          if (tlast) begin
            state_d = DRAIN;
          end else if (count_d == CW'(MAX_LEN)) begin
            state_d = DRAIN;
            trunc_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (olast) begin
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = LOAD_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD_IDLE;
    endcase
    tready_d = (state_d != DRAIN);
  end

  always_comb begin
    ovalid = (state_q == DRAIN);
    olast  = (state_q == DRAIN) && (rd_ptr_q == count_q - CW'(1));
    odata  = (state_q == DRAIN) ? mem_q[IW'(rd_ptr_q)] : '0;
    busy   = (state_q != LOAD_IDLE);
    tready = tready_q;
    trunc  = trunc_q;
  end

endmodule

// File: tb/tb_axis_sort_param.sv
// Bench for axis_sort_param: a 16-bit unsigned instance and an 8-bit signed MAX_LEN=4 instance,
// checked against a stable selection-sort reference.
module tb_axis_sort_param;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        descending = 1'b0;
  logic        tlast = 1'b0;
  logic        oready = 1'b0;
  logic [15:0] tdata = '0;
  logic        m_tvalid = 1'b0;
  logic        s_tvalid = 1'b0;
  bit          sel = 1'b0;
  int          ready_pct = 100;

  logic        m_tready, m_ovalid, m_olast, m_busy, m_trunc;
  logic [15:0] m_odata;
  logic        s_tready, s_ovalid, s_olast, s_busy, s_trunc;
  logic [7:0]  s_odata;

  logic        obs_tready, obs_ovalid, obs_olast, obs_busy, obs_trunc;
  logic [15:0] obs_odata;

  int  checks = 0;
  int  passes = 0;
  iq_t out_q;
  bit  last_q[$];
  int  trunc_cnt = 0;
  int  hold_err = 0;
  int  inv_err = 0;
  bit  stall = 1'b0;
  bit  trunc_prev = 1'b0;
  logic [15:0] hold_d = '0;
  logic        hold_l = 1'b0;

  always #5 clk = ~clk;

  axis_sort_param #(.DATA_WIDTH(16), .MAX_LEN(16), .SIGNED_CMP(1'b0)) u_main (
    .clk(clk), .reset(reset), .descending(descending),
    .tvalid(m_tvalid), .tready(m_tready), .tlast(tlast), .tdata(tdata),
    .ovalid(m_ovalid), .oready(oready), .olast(m_olast), .odata(m_odata),
    .busy(m_busy), .trunc(m_trunc)
  );

  axis_sort_param #(.DATA_WIDTH(8), .MAX_LEN(4), .SIGNED_CMP(1'b1)) u_sgn (
    .clk(clk), .reset(reset), .descending(descending),
    .tvalid(s_tvalid), .tready(s_tready), .tlast(tlast), .tdata(tdata[7:0]),
    .ovalid(s_ovalid), .oready(oready), .olast(s_olast), .odata(s_odata),
    .busy(s_busy), .trunc(s_trunc)
  );

  assign obs_tready = sel ? s_tready : m_tready;
  assign obs_ovalid = sel ? s_ovalid : m_ovalid;
  assign obs_olast  = sel ? s_olast  : m_olast;
  assign obs_busy   = sel ? s_busy   : m_busy;
  assign obs_trunc  = sel ? s_trunc  : m_trunc;
  assign obs_odata  = sel ? {8'h00, s_odata} : m_odata;

  // Downstream ready is chosen right after each rising edge, so it is stable when sampled.
  always @(posedge clk) oready <= ($urandom_range(99) < ready_pct);

  // Output collector and protocol watcher for the selected instance.
  always @(negedge clk) begin
    if (reset) begin
      stall      <= 1'b0;
      trunc_prev <= 1'b0;
    end else begin
      trunc_prev <= obs_trunc;
      if (obs_trunc) trunc_cnt <= trunc_cnt + 1;
      if (obs_trunc && trunc_prev) inv_err <= inv_err + 1;
      if (obs_ovalid && obs_tready) inv_err <= inv_err + 1;
      if (obs_ovalid && stall && (obs_odata !== hold_d || obs_olast !== hold_l))
        hold_err <= hold_err + 1;
      if (obs_ovalid && oready) begin
        out_q.push_back(int'(obs_odata));
        last_q.push_back(obs_olast);
        stall <= 1'b0;
      end else if (obs_ovalid) begin
        stall  <= 1'b1;
        hold_d <= obs_odata;
        hold_l <= obs_olast;
      end else begin
        stall <= 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic int key(input int w, input bit sgn8);
    return (sgn8 && w >= 128) ? w - 256 : w;
  endfunction

  // Stable sort by repeated selection of the earliest extreme element.
  function automatic iq_t ref_sort(input iq_t in_q, input bit desc, input bit sgn8);
    iq_t src = in_q;
    iq_t r;
    while (src.size() > 0) begin
      int b = 0;
      for (int j = 1; j < src.size(); j++) begin
        if (desc ? (key(src[j], sgn8) > key(src[b], sgn8))
                 : (key(src[j], sgn8) < key(src[b], sgn8))) b = j;
      end
      r.push_back(src[b]);
      src.delete(b);
    end
    return r;
  endfunction

  // Drives words honouring tready; descending is only held at the first word of each chunk.
  task automatic send(input iq_t w, input bit desc, input int maxlen, input bit use_last);
    for (int i = 0; i < w.size(); i++) begin
      int n = 0;
      descending = ((i % maxlen) == 0) ? desc : !desc;
      tdata      = 16'(w[i]);
      tlast      = use_last && (i == w.size() - 1);
      m_tvalid   = !sel;
      s_tvalid   = sel;
      while (!obs_tready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        check("tready_timeout", 32'(n), 32'(0));
        break;
      end
      @(negedge clk);
    end
    m_tvalid = 1'b0;
    s_tvalid = 1'b0;
    tlast    = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input iq_t exp, input int base);
    int n = 0;
    while (out_q.size() < base + exp.size() && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count"}, 32'(out_q.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < out_q.size()) begin
        check($sformatf("%s_data%0d", tag, i), 32'(out_q[base+i]), 32'(exp[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(last_q[base+i]), 32'(i == exp.size() - 1));
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (obs_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_return", 32'(obs_busy), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    iq_t w, e, e2;
    int  base, tc;
    bit  d;

    repeat (2) @(negedge clk);
    check("rst_tready", 32'(m_tready), 32'(0));
    check("rst_ovalid", 32'(m_ovalid), 32'(0));
    check("rst_olast",  32'(m_olast),  32'(0));
    check("rst_odata",  32'(m_odata),  32'(0));
    check("rst_busy",   32'(m_busy),   32'(0));
    check("rst_trunc",  32'(m_trunc),  32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 32'(m_tready), 32'(1));

    // Ascending known answer plus one-cycle drain latency.
    base = out_q.size();
    w = {5, 3, 9, 1};
    send(w, 1'b0, 16, 1'b1);
    check("lat_ovalid", 32'(m_ovalid), 32'(1));
    check("lat_tready", 32'(m_tready), 32'(0));
    check("lat_busy",   32'(m_busy),   32'(1));
    e = {1, 3, 5, 9};
    expect_pkt("asc", e, base);
    wait_idle();

    // Descending with duplicates; mode flips after the first word and must be ignored.
    base = out_q.size();
    w = {7, 2, 7, 4};
    send(w, 1'b1, 16, 1'b1);
    e = {7, 7, 4, 2};
    expect_pkt("desc_dup", e, base);
    wait_idle();

    // Unsigned ordering of byte-range values.
    base = out_q.size();
    w = {'h80, 'h7F, 'h00, 'hFF};
    send(w, 1'b0, 16, 1'b1);
    e = {'h00, 'h7F, 'h80, 'hFF};
    expect_pkt("unsigned", e, base);
    wait_idle();

    // Signed 8-bit instance, packet exactly MAX_LEN long with tlast: no truncation.
    sel = 1'b1;
    @(negedge clk);
    base = out_q.size();
    tc = trunc_cnt;
    send(w, 1'b0, 4, 1'b1);
    e = {'h80, 'hFF, 'h00, 'h7F};
    expect_pkt("signed", e, base);
    wait_idle();
    check("signed_no_trunc", 32'(trunc_cnt - tc), 32'(0));

    // Six words into a depth-4 sorter: truncated packet then the remainder.
    base = out_q.size();
    tc = trunc_cnt;
    w = {};
    for (int i = 0; i < 6; i++) w.push_back(int'($urandom_range(255)));
    d = 1'($urandom_range(1));
    send(w, d, 4, 1'b1);
    e  = ref_sort(w[0:3], d, 1'b1);
    e2 = ref_sort(w[4:5], d, 1'b1);
    expect_pkt("trunc4_p1", e, base);
    expect_pkt("trunc4_p2", e2, base + 4);
    wait_idle();
    check("trunc4_pulses", 32'(trunc_cnt - tc), 32'(1));
    sel = 1'b0;
    @(negedge clk);

    // Random packets under 50% backpressure: lengths 1, 16, small-range duplicates, random.
    ready_pct = 50;
    for (int p = 0; p < 4; p++) begin
      int len;
      len = (p == 0) ? 1 : (p == 1) ? 16 : (p == 2) ? 8 : int'($urandom_range(2, 16));
      w = {};
      for (int i = 0; i < len; i++)
        w.push_back((p == 2) ? int'($urandom_range(7)) : int'($urandom_range(65535)));
      d = 1'($urandom_range(1));
      base = out_q.size();
      tc = trunc_cnt;
      send(w, d, 16, 1'b1);
      e = ref_sort(w, d, 1'b0);
      expect_pkt($sformatf("rand%0d", p), e, base);
      wait_idle();
      check($sformatf("rand%0d_no_trunc", p), 32'(trunc_cnt - tc), 32'(0));
    end

    // 18 words into the depth-16 sorter under backpressure.
    base = out_q.size();
    tc = trunc_cnt;
    w = {};
    for (int i = 0; i < 18; i++) w.push_back(int'($urandom_range(65535)));
    d = 1'($urandom_range(1));
    send(w, d, 16, 1'b1);
    e  = ref_sort(w[0:15], d, 1'b0);
    e2 = ref_sort(w[16:17], d, 1'b0);
    expect_pkt("trunc16_p1", e, base);
    expect_pkt("trunc16_p2", e2, base + 16);
    wait_idle();
    check("trunc16_pulses", 32'(trunc_cnt - tc), 32'(1));
    ready_pct = 100;

    // Reset during load at the third word.
    base = out_q.size();
    w = {11, 12};
    send(w, 1'b0, 16, 1'b0);
    m_tvalid = 1'b1;
    tdata    = 16'd13;
    reset    = 1'b1;
    @(negedge clk);
    check("rst_load_ovalid", 32'(m_ovalid), 32'(0));
    check("rst_load_busy",   32'(m_busy),   32'(0));
    m_tvalid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    // Reset mid-drain while downstream stalls.
    ready_pct = 0;
    repeat (2) @(negedge clk);
    w = {40, 30, 20, 10};
    send(w, 1'b0, 16, 1'b1);
    repeat (2) @(negedge clk);
    check("drain_before_rst", 32'(m_ovalid), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rst_drain_ovalid", 32'(m_ovalid), 32'(0));
    check("rst_drain_busy",   32'(m_busy),   32'(0));
    reset = 1'b0;
    ready_pct = 100;
    @(negedge clk);
    check("rst_no_output", 32'(out_q.size() - base), 32'(0));

    w = {2, 1};
    send(w, 1'b0, 16, 1'b1);
    e = {1, 2};
    expect_pkt("post_rst", e, base);
    wait_idle();
    repeat (4) @(negedge clk);
    check("post_rst_no_stale", 32'(out_q.size() - base), 32'(2));

    check("hold_stability", 32'(hold_err), 32'(0));
    check("protocol_invariants", 32'(inv_err), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
